exe_branch_ctrl: RTL and testbench
==================================

EXE_BRANCH_CTRL -- requirements
Module: exe_branch_ctrl

Interface
REQ-001 Parameter SHADOW, default 1, range 1..3: number of ID/EX slots squashed after a taken branch.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset: asynchronous, active-high.
REQ-004 freeze  in  1  pipeline stall from memory stage; ID/EX contents held while high.
REQ-005 b, s_in, wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  decoded fields from ID/EX register.
REQ-006 pc  in  32  ID/EX pc field (already PC+4).
REQ-007 imm_signed_24  in  24  branch offset field from ID/EX register.
REQ-008 alu_nzcv  in  4  flags produced by ALU for the current ID/EX instruction.
REQ-009 flush  out  1  redirect fetch and clear IF/ID.
REQ-010 branch_addr  out  32  redirect target, valid while flush=1.
REQ-011 wb_en, mem_r_en, mem_w_en  out  1 each  enables after squash masking.
REQ-012 status  out  4  architectural NZCV register.
REQ-013 branch_cnt  out  16  taken-branch count (see Configuration).

Function
REQ-014 Slot is "killed" when kill_cnt != 0; live otherwise.
REQ-015 wb_en/mem_r_en/mem_w_en SHALL equal inputs when live, 0 when killed or pend=1; combinational.
REQ-016 Target SHALL be pc + (sign_extend(imm_signed_24) << 2), 32-bit modulo (wrap, no overflow flag).
REQ-017 Live b=1 with freeze=0 and pend=0: flush=1 and branch_addr=target same cycle; next edge loads kill_cnt=SHADOW.
REQ-018 Live b=1 with freeze=1: flush=0; next edge sets pend=1 and latches target into pend_addr.
REQ-019 pend=1 and freeze=0: flush=1, branch_addr=pend_addr; next edge clears pend, loads kill_cnt=SHADOW.
REQ-020 pend=1 and freeze=1: flush=0, pend and pend_addr held; b ignored.
REQ-021 kill_cnt SHALL decrement by 1 per edge with freeze=0 and kill_cnt!=0; hold while freeze=1; never underflow.
REQ-022 b=1 in a killed slot SHALL be ignored (no flush, no pend, no count).
REQ-023 flush SHALL be exactly one cycle per taken branch; back-to-back live branches impossible by REQ-022.
REQ-024 status SHALL load alu_nzcv on edge when s_in=1, slot live, pend=0, freeze=0; hold otherwise.
REQ-025 A branch with s_in=1 SHALL update status on its flush cycle.

Reset
REQ-026 rst=1 SHALL immediately force: flush=0, branch_addr=0, status=0, kill_cnt=0, pend=0, pend_addr=0, branch_cnt=0.
REQ-027 Masked enables SHALL pass inputs through while rst=1 (kill_cnt=0, pend=0).
REQ-028 rst asserted mid-pend or mid-shadow SHALL abandon the redirect; first post-reset slot is live.

Configuration
REQ-029 Macro EXE_BRANCH_CNT_EN defined: branch_cnt increments (wrap 0xFFFF->0) on each edge ending a flush=1 cycle.
REQ-030 Macro undefined: counter not instantiated, branch_cnt tied to 16'h0000; all other behaviour identical.

Structure
REQ-031 Shared package arm_pkg SHALL hold NZCV bit-index constants, the pipeline width constant 32, and the offset shift constant 2.
REQ-032 Target adder SHALL be sub-module branch_target_adder (pc, imm_signed_24 -> target), purely combinational.
REQ-033 kill_cnt width SHALL be 2 bits; pend_addr 32 bits.

Verification
REQ-034 pc=0x100, imm=0x000004, b=1, freeze=0 -> flush=1 and branch_addr=0x110 same cycle; next cycle wb_en=0 with wb_en_in=1.
REQ-035 pc=0x10, imm=0xFFFFFC, b=1 -> branch_addr=0x0; pc=0xFFFFFFFC, imm=0x000001 -> branch_addr=0x0 (wrap).
REQ-036 b=1 with freeze=1 for 3 cycles -> flush=0 throughout; cycle freeze drops: flush=1, branch_addr=latched target, exactly one cycle.
REQ-037 SHADOW=2, branch then b=1 in both shadow slots -> single flush, both slots masked, third slot live.
REQ-038 s_in=1, alu_nzcv=4'b1010 live -> status=1010 after edge; same in killed slot or with freeze=1 -> status unchanged.
REQ-039 rst pulse during pend=1 -> flush never asserts, status=0, branch_cnt=0; with EXE_BRANCH_CNT_EN, 3 taken branches -> branch_cnt=3.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM execute-stage constants: datapath width, branch offset geometry,
// NZCV bit positions and the branch-control state type.
package arm_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned IMM_W        = 24;
  localparam int unsigned OFFSET_SHIFT = 2;
  localparam int unsigned NZCV_W       = 4;
  localparam int unsigned KILL_W       = 2;
  localparam int unsigned BCNT_W       = 16;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_PEND = 1'b1
  } br_state_e;

  // Word offset -> sign-extended byte offset (imm * 4).
  function automatic logic [XLEN-1:0] sext_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-OFFSET_SHIFT){imm[IMM_W-1]}}, imm, {OFFSET_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target: pc + (sign_extend(imm_signed_24) << 2), modulo 2^32.
module branch_target_adder
  import arm_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [IMM_W-1:0] imm_signed_24,
  output logic [XLEN-1:0]  target
);

  assign target = pc + sext_offset(imm_signed_24);

endmodule

// File: rtl/exe_branch_ctrl.sv
// Execute-stage branch control: redirect, shadow-slot squashing, stalled-branch
// deferral and NZCV update. Define EXE_BRANCH_CNT_EN to build the taken-branch counter.
module exe_branch_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned SHADOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              b,
  input  logic              s_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [XLEN-1:0]   pc,
  input  logic [IMM_W-1:0]  imm_signed_24,
  input  logic [NZCV_W-1:0] alu_nzcv,
  output logic              flush,
  output logic [XLEN-1:0]   branch_addr,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [NZCV_W-1:0] status,
  output logic [BCNT_W-1:0] branch_cnt
);

  localparam logic [KILL_W-1:0] SHADOW_LD = KILL_W'(SHADOW);

  br_state_e         r_state;
  br_state_e         w_state_nxt;
  logic [KILL_W-1:0] r_kill_cnt;
  logic [KILL_W-1:0] w_kill_cnt_nxt;
  logic [XLEN-1:0]   r_pend_addr;
  logic [XLEN-1:0]   w_pend_addr_nxt;
  logic [NZCV_W-1:0] r_status;
  logic [NZCV_W-1:0] w_status_nxt;
  logic [XLEN-1:0]   w_target;
  logic              w_live;
  logic              w_pass;
  logic              w_flush;
  logic [XLEN-1:0]   w_branch_addr;

  branch_target_adder u_target (
    .pc            (pc),
    .imm_signed_24 (imm_signed_24),
    .target        (w_target)
  );

  assign w_live = (r_kill_cnt == '0);
  assign w_pass = w_live && (r_state == BR_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BR_IDLE;
      r_kill_cnt  <= '0;
      r_pend_addr <= '0;
      r_status    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_kill_cnt  <= w_kill_cnt_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_status    <= w_status_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_kill_cnt_nxt  = r_kill_cnt;
    w_pend_addr_nxt = r_pend_addr;
    w_status_nxt    = r_status;
    w_flush         = 1'b0;
    w_branch_addr   = '0;

    unique case (r_state)
      // Deferred redirect fires on the first unfrozen cycle; the slot is masked.
      BR_PEND: begin
        if (!freeze) begin
          w_flush        = 1'b1;
          w_branch_addr  = r_pend_addr;
          w_state_nxt    = BR_IDLE;
          w_kill_cnt_nxt = SHADOW_LD;
        end
      end
      default: begin
        if (w_live) begin
          if (b && !freeze) begin
            w_flush        = 1'b1;
            w_branch_addr  = w_target;
            w_kill_cnt_nxt = SHADOW_LD;
          end else if (b) begin
            w_state_nxt     = BR_PEND;
            w_pend_addr_nxt = w_target;
          end
          if (s_in && !freeze) begin
            w_status_nxt = alu_nzcv;
          end
        end else if (!freeze) begin
          w_kill_cnt_nxt = r_kill_cnt - KILL_W'(1);
        end
      end
    endcase

    // Reset must silence the redirect immediately, before the registers settle.
    if (rst) begin
      w_flush       = 1'b0;
      w_branch_addr = '0;
    end
  end

  assign flush       = w_flush;
  assign branch_addr = w_branch_addr;
  assign wb_en       = wb_en_in    & w_pass;
  assign mem_r_en    = mem_r_en_in & w_pass;
  assign mem_w_en    = mem_w_en_in & w_pass;
  assign status      = r_status;

`ifdef EXE_BRANCH_CNT_EN
  logic [BCNT_W-1:0] r_branch_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt <= '0;
    end else if (w_flush) begin
      r_branch_cnt <= r_branch_cnt + BCNT_W'(1);
    end
  end

  assign branch_cnt = r_branch_cnt;
`else
  assign branch_cnt = '0;
`endif

endmodule

// File: tb/tb_exe_branch_ctrl.sv
// Scoreboard bench for exe_branch_ctrl: directed scenarios plus random traffic,
// expected outputs produced by a slot-level reference model.
module tb_exe_branch_ctrl;

  localparam int unsigned SHADOW = 2;
`ifdef EXE_BRANCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        b;
  logic        s_in;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] pc;
  logic [23:0] imm_signed_24;
  logic [3:0]  alu_nzcv;
  logic        flush;
  logic [31:0] branch_addr;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  status;
  logic [15:0] branch_cnt;

  typedef struct {
    logic        flush;
    logic [31:0] addr;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  status;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: squashed slots remaining, deferred redirect, flags, count.
  int          m_shadow;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  logic [3:0]  m_status;
  logic [15:0] m_cnt;

  exe_branch_ctrl #(.SHADOW(SHADOW)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .b             (b),
    .s_in          (s_in),
    .wb_en_in      (wb_en_in),
    .mem_r_en_in   (mem_r_en_in),
    .mem_w_en_in   (mem_w_en_in),
    .pc            (pc),
    .imm_signed_24 (imm_signed_24),
    .alu_nzcv      (alu_nzcv),
    .flush         (flush),
    .branch_addr   (branch_addr),
    .wb_en         (wb_en),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .status        (status),
    .branch_cnt    (branch_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Predict this slot's outputs, queue them, then advance the model across the next edge.
  task automatic model_step(input logic r, input logic f, input logic bb, input logic s,
                            input logic wb, input logic mr, input logic mw,
                            input logic [31:0] p, input logic [23:0] im, input logic [3:0] nz);
    exp_t        e;
    logic [31:0] tgt;
    bit          killed;
    bit          live;
    tgt = p + 32'(int'($signed(im)) * 4);
    if (r) begin
      m_shadow = 0; m_pend = 1'b0; m_pend_addr = '0; m_status = '0; m_cnt = '0;
      e = '{flush: 1'b0, addr: 32'h0, wb: wb, mr: mr, mw: mw, status: 4'h0, cnt: 16'h0};
      exp_q.push_back(e);
      return;
    end
    killed = (m_shadow != 0);
    live   = !killed && !m_pend;
    e.flush = 1'b0;
    e.addr  = 32'h0;
    if (m_pend) begin
      if (!f) begin e.flush = 1'b1; e.addr = m_pend_addr; end
    end else if (!killed && bb && !f) begin
      e.flush = 1'b1; e.addr = tgt;
    end
    e.wb     = wb & live;
    e.mr     = mr & live;
    e.mw     = mw & live;
    e.status = m_status;
    e.cnt    = CNT_EN ? m_cnt : 16'h0;
    exp_q.push_back(e);
    if (live && s && !f) m_status = nz;
    if (e.flush) m_cnt = m_cnt + 16'h1;
    if (m_pend) begin
      if (!f) begin m_pend = 1'b0; m_shadow = SHADOW; end
    end else if (killed) begin
      if (!f) m_shadow = m_shadow - 1;
    end else if (bb) begin
      if (f) begin m_pend = 1'b1; m_pend_addr = tgt; end
      else m_shadow = SHADOW;
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic bb, input logic s,
                       input logic wb, input logic mr, input logic mw,
                       input logic [31:0] p, input logic [23:0] im, input logic [3:0] nz);
    @(posedge clk);
    #1;
    rst = r; freeze = f; b = bb; s_in = s;
    wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw;
    pc = p; imm_signed_24 = im; alu_nzcv = nz;
    model_step(r, f, bb, s, wb, mr, mw, p, im, nz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 24'h0, 4'h0);
  endtask

  // Monitor: every output is checked each cycle against the queued prediction.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("flush",       32'(flush),      32'(mon_e.flush));
      chk("branch_addr", branch_addr,     mon_e.addr);
      chk("wb_en",       32'(wb_en),      32'(mon_e.wb));
      chk("mem_r_en",    32'(mem_r_en),   32'(mon_e.mr));
      chk("mem_w_en",    32'(mem_w_en),   32'(mon_e.mw));
      chk("status",      32'(status),     32'(mon_e.status));
      chk("branch_cnt",  32'(branch_cnt), 32'(mon_e.cnt));
    end
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; b = 1'b0; s_in = 1'b0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    pc = '0; imm_signed_24 = '0; alu_nzcv = '0;
    m_shadow = 0; m_pend = 1'b0; m_pend_addr = '0; m_status = '0; m_cnt = '0;

    // Reset with a live-looking branch on the inputs: no redirect, enables pass.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 24'h4, 4'hF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 24'h0, 4'h0);
    idle(1);

    // Basic taken branch, then the shadow slots masked.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 24'h000004, 4'h0);
    idle(3);

    // Negative offset and 32-bit wrap.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 24'hFFFFFC, 4'h0);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 24'h000001, 4'h0);
    idle(2);

    // Branch stalled for three cycles, redirect on the release cycle.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 24'h000010, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 24'h000010, 4'h0);
    idle(3);

    // Branches in both shadow slots are ignored; third slot live.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 24'h000100, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h304, 24'h000200, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h308, 24'h000300, 4'h0);
    idle(2);

    // Status update: live, killed slot, frozen slot, branch with s_in.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 24'h0, 4'b1010);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404, 24'h8, 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h408, 24'h0, 4'b0101);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40C, 24'h0, 4'b0110);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h410, 24'h8, 4'b0011);
    idle(3);

    // Reset pulse while a redirect is pending.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 24'h20, 4'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 24'h20, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 24'h20, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h500, 24'h20, 4'h0);
    idle(3);

    // Three taken branches for the counter.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h600 + 32'(i * 16), 24'h4, 4'h0);
      idle(SHADOW + 1);
    end

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, 24'($urandom), 4'($urandom));
    end
    idle(2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
